ctrl_fsm: RTL and testbench

Main control state machine of the 16-bit processor. After reset it runs an init mode that copies program words from WISHBONE into PRAM. It then fetches instructions from PRAM and decodes them into ALU, register-file, WISHBONE, segment-register and program-counter controls. It also handles interrupts, multi-cycle ALU ops and an external sync barrier.

---
 rtl/ctrl_fsm.sv | 243 ++++++++++++++++++++++++
 tb/tb_ctrl_fsm.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_fsm.sv
// Main control FSM of the 16-bit processor: init copy mode, fetch/decode,
// WISHBONE load/store/return, multi-cycle ALU waits, interrupts and sync barrier.
module ctrl_fsm #(
  parameter int INSTR_WIDTH   = 16,
  parameter int ADDR_WIDTH_OP = 4,
  parameter int ADDR_WIDTH_PC = 12,
  parameter int OPCODE_LGNT   = 8,
  parameter int JMPR_OPCODE   = 4,
  parameter int SEG_REG_WIDTH = 4
) (
  input  logic                     clk_i,
  input  logic                     a_reset_l,
  input  logic [INSTR_WIDTH-1:0]   out_data_pram_i,
  input  logic                     intr_h_i,
  input  logic                     ovr_i,
  input  logic                     valid_i,
  input  logic                     wb_ack_i,
  input  logic [INSTR_WIDTH-1:0]   data_b_bus_i,
  input  logic [INSTR_WIDTH-1:0]   data_wb_bus_i,
  input  logic                     mask_i,
  input  logic                     sync_h_i,
  input  logic                     alu_valid_i,
  output logic [OPCODE_LGNT-1:0]   alu_op_o,
  output logic                     wb_we_o,
  output logic                     wb_start_o,
  output logic                     regfile_we_o,
  output logic [ADDR_WIDTH_OP-1:0] adr_a_o,
  output logic [ADDR_WIDTH_OP-1:0] adr_b_o,
  output logic                     seg_reg_we_o,
  output logic [SEG_REG_WIDTH-1:0] seg_reg_o,
  output logic                     adr_ld_o,
  output logic [ADDR_WIDTH_PC-1:0] adr_pc_o,
  output logic                     init_mode_o,
  output logic [1:0]               alu_mux_o,
  output logic [1:0]               sp_mux_o,
  output logic [1:0]               data_mux_o,
  output logic                     inc_o
);

  typedef enum logic [3:0] {
    S_INIT,
    S_FETCH,
    S_EXEC,
    S_WAIT_ALU,
    S_WAIT_WB,
    S_WAIT_RET,
    S_WAIT_SYNC,
    S_INT_PUSH,
    S_INT_JMP
  } state_t;

  localparam logic [OPCODE_LGNT-1:0]   OP_NOP      = 'h00;
  localparam logic [OPCODE_LGNT-1:0]   OP_ALU_LAST = 'h1F;
  localparam logic [OPCODE_LGNT-1:0]   OP_MD_FIRST = 'h20;
  localparam logic [OPCODE_LGNT-1:0]   OP_MD_LAST  = 'h2F;
  localparam logic [OPCODE_LGNT-1:0]   OP_LOAD     = 'h40;
  localparam logic [OPCODE_LGNT-1:0]   OP_STORE    = 'h41;
  localparam logic [OPCODE_LGNT-1:0]   OP_SEG      = 'h50;
  localparam logic [OPCODE_LGNT-1:0]   OP_JMPR     = 'h60;
  localparam logic [OPCODE_LGNT-1:0]   OP_RETI     = 'h61;
  localparam logic [OPCODE_LGNT-1:0]   OP_SYNC     = 'h70;
  localparam logic [ADDR_WIDTH_PC-1:0] INT_VECTOR  = 'h004;

  state_t                   state_q, state_d;
  logic [INSTR_WIDTH-1:0]   ir_q, ir_d;
  logic                     push_busy_q, push_busy_d;
  logic [OPCODE_LGNT-1:0]   opcode;
  logic                     is_jmp_abs;
  logic                     unused_bus_bits;

  assign opcode          = ir_q[INSTR_WIDTH-1 -: OPCODE_LGNT];
  assign is_jmp_abs      = (ir_q[INSTR_WIDTH-1 -: JMPR_OPCODE] == '1);
  assign unused_bus_bits = ^{data_b_bus_i[INSTR_WIDTH-1:ADDR_WIDTH_PC],
                             data_wb_bus_i[INSTR_WIDTH-1:ADDR_WIDTH_PC]};

  always_ff @(posedge clk_i or negedge a_reset_l) begin
    if (!a_reset_l) begin
      state_q     <= S_INIT;
      ir_q        <= '0;
      push_busy_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ir_q        <= ir_d;
      push_busy_q <= push_busy_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    ir_d         = ir_q;
    push_busy_d  = 1'b0;
    alu_op_o     = '0;
    wb_we_o      = 1'b0;
    wb_start_o   = 1'b0;
    regfile_we_o = 1'b0;
    adr_a_o      = '0;
    adr_b_o      = '0;
    seg_reg_we_o = 1'b0;
    seg_reg_o    = '0;
    adr_ld_o     = 1'b0;
    adr_pc_o     = '0;
    init_mode_o  = 1'b0;
    alu_mux_o    = 2'b00;
    sp_mux_o     = 2'b00;
    data_mux_o   = 2'b00;
    inc_o        = 1'b0;

    if (state_q inside {S_EXEC, S_WAIT_ALU, S_WAIT_WB, S_WAIT_RET, S_WAIT_SYNC}) begin
      adr_a_o = ir_q[2*ADDR_WIDTH_OP-1:ADDR_WIDTH_OP];
      adr_b_o = ir_q[ADDR_WIDTH_OP-1:0];
    end

    case (state_q)
      S_INIT: begin
        init_mode_o = 1'b1;
        // An overrun restarts the copy from address 0 and drops the pending word
        if (ovr_i) begin
          adr_ld_o = 1'b1;
        end else begin
          inc_o = valid_i;
        end
        if (sync_h_i) begin
          adr_ld_o = 1'b1;
          state_d  = S_FETCH;
        end
      end

      S_FETCH: begin
        if (intr_h_i && !mask_i) begin
          state_d = S_INT_PUSH;
        end else begin
          ir_d    = out_data_pram_i;
          inc_o   = 1'b1;
          state_d = S_EXEC;
        end
      end

      S_EXEC: begin
        state_d = S_FETCH;
        if (is_jmp_abs) begin
          adr_ld_o = 1'b1;
          adr_pc_o = ir_q[ADDR_WIDTH_PC-1:0];
        end else if (opcode != OP_NOP && opcode <= OP_ALU_LAST) begin
          alu_op_o     = opcode;
          alu_mux_o    = 2'b10;
          regfile_we_o = 1'b1;
        end else if (opcode >= OP_MD_FIRST && opcode <= OP_MD_LAST) begin
          alu_op_o = opcode;
          state_d  = S_WAIT_ALU;
        end else begin
          case (opcode)
            OP_LOAD: begin
              wb_start_o = 1'b1;
              sp_mux_o   = 2'b10;
              state_d    = S_WAIT_WB;
            end
            OP_STORE: begin
              wb_start_o = 1'b1;
              wb_we_o    = 1'b1;
              data_mux_o = 2'b01;
              sp_mux_o   = 2'b10;
              state_d    = S_WAIT_WB;
            end
            OP_SEG: begin
              seg_reg_we_o = 1'b1;
              seg_reg_o    = ir_q[SEG_REG_WIDTH-1:0];
            end
            OP_JMPR: begin
              adr_ld_o = 1'b1;
              adr_pc_o = data_b_bus_i[ADDR_WIDTH_PC-1:0];
            end
            OP_RETI: begin
              wb_start_o = 1'b1;
              sp_mux_o   = 2'b01;
              state_d    = S_WAIT_RET;
            end
            OP_SYNC: state_d = S_WAIT_SYNC;
            default: ;
          endcase
        end
      end

      S_WAIT_ALU: begin
        alu_op_o = opcode;
        if (alu_valid_i) begin
          regfile_we_o = 1'b1;
          alu_mux_o    = 2'b10;
          state_d      = S_FETCH;
        end
      end

      S_WAIT_WB: begin
        sp_mux_o = 2'b10;
        if (opcode == OP_STORE) begin
          wb_we_o    = 1'b1;
          data_mux_o = 2'b01;
        end
        if (wb_ack_i) begin
          if (opcode != OP_STORE) begin
            regfile_we_o = 1'b1;
            alu_mux_o    = 2'b01;
          end
          state_d = S_FETCH;
        end
      end

      S_WAIT_RET: begin
        sp_mux_o = 2'b01;
        if (wb_ack_i) begin
          adr_ld_o = 1'b1;
          adr_pc_o = data_wb_bus_i[ADDR_WIDTH_PC-1:0];
          state_d  = S_FETCH;
        end
      end

      S_WAIT_SYNC: begin
        if (sync_h_i) state_d = S_FETCH;
      end

      S_INT_PUSH: begin
        // push_busy_q keeps the start strobe to the first cycle of the push
        wb_we_o    = 1'b1;
        data_mux_o = 2'b10;
        sp_mux_o   = 2'b01;
        wb_start_o = !push_busy_q;
        if (wb_ack_i) begin
          state_d = S_INT_JMP;
        end else begin
          push_busy_d = 1'b1;
        end
      end

      S_INT_JMP: begin
        adr_ld_o = 1'b1;
        adr_pc_o = INT_VECTOR;
        state_d  = S_FETCH;
      end

      default: state_d = S_INIT;
    endcase
  end

endmodule

// File: tb/tb_ctrl_fsm.sv
// Self-checking bench for ctrl_fsm: a per-cycle vector table followed by
// hand-written multi-cycle sequences (WISHBONE waits, mult/div, interrupt, reset).
module tb_ctrl_fsm;

  typedef struct packed {
    logic [15:0] pram;
    logic        intr;
    logic        mask;
    logic        ovr;
    logic        valid;
    logic        ack;
    logic [15:0] b_bus;
    logic [15:0] wb_bus;
    logic        sync;
    logic        alu_valid;
  } ins_t;

  typedef struct packed {
    logic [7:0]  alu_op;
    logic        wb_we;
    logic        wb_start;
    logic        regfile_we;
    logic [3:0]  adr_a;
    logic [3:0]  adr_b;
    logic        seg_we;
    logic [3:0]  seg;
    logic        adr_ld;
    logic [11:0] adr_pc;
    logic        init_mode;
    logic [1:0]  alu_mux;
    logic [1:0]  sp_mux;
    logic [1:0]  data_mux;
    logic        inc;
  } outs_t;

  typedef struct {
    string name;
    ins_t  i;
    outs_t o;
  } vec_t;

  logic        clk = 1'b0;
  logic        a_reset_l;
  logic [15:0] out_data_pram;
  logic        intr_h, ovr, valid, wb_ack, mask, sync_h, alu_valid;
  logic [15:0] data_b_bus, data_wb_bus;
  logic [7:0]  alu_op;
  logic        wb_we, wb_start, regfile_we, seg_reg_we, adr_ld, init_mode, inc;
  logic [3:0]  adr_a, adr_b, seg_reg;
  logic [11:0] adr_pc;
  logic [1:0]  alu_mux, sp_mux, data_mux;
  outs_t       act;

  int n_checks = 0;
  int n_fail   = 0;
  int start_count;
  vec_t vecs[$];

  always #5 clk = ~clk;

  ctrl_fsm dut (
    .clk_i           (clk),
    .a_reset_l       (a_reset_l),
    .out_data_pram_i (out_data_pram),
    .intr_h_i        (intr_h),
    .ovr_i           (ovr),
    .valid_i         (valid),
    .wb_ack_i        (wb_ack),
    .data_b_bus_i    (data_b_bus),
    .data_wb_bus_i   (data_wb_bus),
    .mask_i          (mask),
    .sync_h_i        (sync_h),
    .alu_valid_i     (alu_valid),
    .alu_op_o        (alu_op),
    .wb_we_o         (wb_we),
    .wb_start_o      (wb_start),
    .regfile_we_o    (regfile_we),
    .adr_a_o         (adr_a),
    .adr_b_o         (adr_b),
    .seg_reg_we_o    (seg_reg_we),
    .seg_reg_o       (seg_reg),
    .adr_ld_o        (adr_ld),
    .adr_pc_o        (adr_pc),
    .init_mode_o     (init_mode),
    .alu_mux_o       (alu_mux),
    .sp_mux_o        (sp_mux),
    .data_mux_o      (data_mux),
    .inc_o           (inc)
  );

  assign act = {alu_op, wb_we, wb_start, regfile_we, adr_a, adr_b, seg_reg_we, seg_reg,
                adr_ld, adr_pc, init_mode, alu_mux, sp_mux, data_mux, inc};

  function automatic outs_t oinit(input logic inc_e, input logic ld_e);
    outs_t e = '0;
    e.init_mode = 1'b1;
    e.inc       = inc_e;
    e.adr_ld    = ld_e;
    return e;
  endfunction

  function automatic outs_t oinc();
    outs_t e = '0;
    e.inc = 1'b1;
    return e;
  endfunction

  function automatic outs_t oir(input logic [15:0] ir);
    outs_t e = '0;
    e.adr_a = ir[7:4];
    e.adr_b = ir[3:0];
    return e;
  endfunction

  task automatic addVec(input string nm, input ins_t i, input outs_t o);
    vec_t v;
    v.name = nm;
    v.i    = i;
    v.o    = o;
    vecs.push_back(v);
  endtask

  // Drive one cycle of inputs just after the falling edge, then settle
  task automatic applyStimulus(input ins_t i);
    @(negedge clk);
    out_data_pram = i.pram;
    intr_h        = i.intr;
    mask          = i.mask;
    ovr           = i.ovr;
    valid         = i.valid;
    wb_ack        = i.ack;
    data_b_bus    = i.b_bus;
    data_wb_bus   = i.wb_bus;
    sync_h        = i.sync;
    alu_valid     = i.alu_valid;
    #1;
  endtask

  task automatic checkOutput(input string nm, input outs_t e);
    n_checks++;
    if (act !== e) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h required %h", nm, act, e);
    end
  endtask

  task automatic step(input string nm, input ins_t i, input outs_t e);
    applyStimulus(i);
    checkOutput(nm, e);
    start_count += int'(wb_start);
  endtask

  initial begin
    ins_t  i;
    outs_t e;

    a_reset_l = 1'b0;
    i = '0;
    out_data_pram = '0; intr_h = 0; mask = 0; ovr = 0; valid = 0; wb_ack = 0;
    data_b_bus = '0; data_wb_bus = '0; sync_h = 0; alu_valid = 0;
    #3;
    checkOutput("reset_state", oinit(1'b0, 1'b0));
    @(negedge clk);
    a_reset_l = 1'b1;

    // Init copy mode, then release into FETCH
    i = '0;              addVec("init_idle",    i, oinit(0, 0));
    i = '0; i.valid = 1; addVec("init_valid1",  i, oinit(1, 0));
    i = '0;              addVec("init_gap",     i, oinit(0, 0));
    i = '0; i.valid = 1; addVec("init_valid2",  i, oinit(1, 0));
    i = '0; i.ovr = 1; i.valid = 1; addVec("init_ovr", i, oinit(0, 1));
    i = '0; i.valid = 1; addVec("init_valid3",  i, oinit(1, 0));
    i = '0; i.sync = 1;  addVec("init_sync",    i, oinit(0, 1));
    // ALU op
    i = '0; i.pram = 16'h0312; addVec("alu_fetch", i, oinc());
    i = '0; e = oir(16'h0312); e.alu_op = 8'h03; e.regfile_we = 1; e.alu_mux = 2'b10;
    addVec("alu_exec", i, e);
    // Absolute jump
    i = '0; i.pram = 16'hF123; addVec("jabs_fetch", i, oinc());
    i = '0; e = oir(16'hF123); e.adr_ld = 1; e.adr_pc = 12'h123;
    addVec("jabs_exec", i, e);
    // Register jump
    i = '0; i.pram = 16'h6000; i.b_bus = 16'h0ABC; addVec("jmpr_fetch", i, oinc());
    i = '0; i.b_bus = 16'h0ABC; e = oir(16'h6000); e.adr_ld = 1; e.adr_pc = 12'hABC;
    addVec("jmpr_exec", i, e);
    // Segment register
    i = '0; i.pram = 16'h5007; addVec("seg_fetch", i, oinc());
    i = '0; e = oir(16'h5007); e.seg_we = 1; e.seg = 4'h7;
    addVec("seg_exec", i, e);
    // NOP and undefined opcode
    i = '0; i.pram = 16'h0000; addVec("nop_fetch", i, oinc());
    i = '0; addVec("nop_exec", i, oir(16'h0000));
    i = '0; i.pram = 16'h8866; addVec("undef_fetch", i, oinc());
    i = '0; addVec("undef_exec", i, oir(16'h8866));
    // Masked interrupt behaves like a normal fetch
    i = '0; i.pram = 16'h0112; i.intr = 1; i.mask = 1; addVec("mask_fetch", i, oinc());
    i = '0; i.intr = 1; i.mask = 1; e = oir(16'h0112); e.alu_op = 8'h01;
    e.regfile_we = 1; e.alu_mux = 2'b10;
    addVec("mask_exec", i, e);

    foreach (vecs[k]) begin
      applyStimulus(vecs[k].i);
      checkOutput(vecs[k].name, vecs[k].o);
    end

    // LOAD with ack three cycles after the start strobe
    start_count = 0;
    i = '0; i.pram = 16'h4050; step("load_fetch", i, oinc());
    i = '0; e = oir(16'h4050); e.wb_start = 1; e.sp_mux = 2'b10; step("load_exec", i, e);
    for (int k = 0; k < 2; k++) begin
      e = oir(16'h4050); e.sp_mux = 2'b10; step("load_wait", i, e);
    end
    i.ack = 1; e = oir(16'h4050); e.sp_mux = 2'b10; e.regfile_we = 1; e.alu_mux = 2'b01;
    step("load_ack", i, e);
    n_checks++;
    if (start_count != 1) begin
      n_fail++;
      $display("[TB] FAIL load_start_pulses: got %0d required 1", start_count);
    end

    // STORE
    i = '0; i.pram = 16'h4123; step("store_fetch", i, oinc());
    i = '0; e = oir(16'h4123); e.wb_start = 1; e.wb_we = 1; e.data_mux = 2'b01;
    e.sp_mux = 2'b10; step("store_exec", i, e);
    e.wb_start = 0; step("store_wait", i, e);
    i.ack = 1; step("store_ack", i, e);

    // Multiply with result valid five cycles later
    i = '0; i.pram = 16'h2034; step("mul_fetch", i, oinc());
    i = '0; e = oir(16'h2034); e.alu_op = 8'h20; step("mul_exec", i, e);
    for (int k = 0; k < 4; k++) step("mul_wait", i, e);
    i.alu_valid = 1; e.regfile_we = 1; e.alu_mux = 2'b10; step("mul_valid", i, e);

    // Unmasked interrupt: push PC, then vector to 0x004
    start_count = 0;
    i = '0; i.pram = 16'h0312; i.intr = 1; step("intr_fetch", i, '0);
    e = '0; e.wb_start = 1; e.wb_we = 1; e.data_mux = 2'b10; e.sp_mux = 2'b01;
    step("intr_push", i, e);
    e.wb_start = 0; step("intr_push_wait", i, e);
    i.ack = 1; step("intr_push_ack", i, e);
    i = '0; e = '0; e.adr_ld = 1; e.adr_pc = 12'h004; step("intr_jmp", i, e);
    n_checks++;
    if (start_count != 1) begin
      n_fail++;
      $display("[TB] FAIL intr_start_pulses: got %0d required 1", start_count);
    end
    i = '0; i.pram = 16'h0000; step("intr_resume_fetch", i, oinc());
    i = '0; step("intr_resume_exec", i, oir(16'h0000));

    // RETI
    i = '0; i.pram = 16'h6100; step("reti_fetch", i, oinc());
    i = '0; e = oir(16'h6100); e.wb_start = 1; e.sp_mux = 2'b01; step("reti_exec", i, e);
    e.wb_start = 0; step("reti_wait", i, e);
    i.ack = 1; i.wb_bus = 16'h1357; e.adr_ld = 1; e.adr_pc = 12'h357; step("reti_ack", i, e);

    // SYNC barrier
    i = '0; i.pram = 16'h7000; step("sync_fetch", i, oinc());
    i = '0; step("sync_exec", i, oir(16'h7000));
    step("sync_wait", i, oir(16'h7000));
    i.sync = 1; step("sync_release", i, oir(16'h7000));
    i = '0; i.pram = 16'h0000; step("sync_next_fetch", i, oinc());
    i = '0; step("sync_next_exec", i, oir(16'h0000));

    // Reset in the middle of a WISHBONE transfer
    i = '0; i.pram = 16'h4050; step("rst_fetch", i, oinc());
    i = '0; e = oir(16'h4050); e.wb_start = 1; e.sp_mux = 2'b10; step("rst_exec", i, e);
    e.wb_start = 0; step("rst_wait", i, e);
    #1 a_reset_l = 1'b0;
    #1 checkOutput("rst_async", oinit(0, 0));
    @(negedge clk);
    a_reset_l = 1'b1;
    i = '0; i.valid = 1; step("rst_init_valid", i, oinit(1, 0));
    i = '0; i.sync = 1;  step("rst_init_sync", i, oinit(0, 1));
    i = '0; i.pram = 16'h0312; step("rst_refetch", i, oinc());

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
